obi_data_arbiter: RTL



---
 rtl/obi_data_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: shares one OBI data master between the core data port
// (requester 0) and the XIF coprocessor memory path (requester 1).
// The address phase is arbitrated combinationally. A granted-but-stalled
// request is held stable until the slave grants it. A small in-order ID FIFO
// records which requester issued each outstanding transaction, so every
// response is routed back to its issuer.
//
// Handshake semantics (OBI):
//   address phase: a transfer happens in the cycle where req && gnt. Once req
//   is raised it must stay high, with stable fields, until gnt is seen.
//   response phase: rvalid has no back-pressure. Each rvalid completes the
//   oldest outstanding transaction.

package obi_data_arbiter_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_data_arbiter
  import obi_data_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          FIXED_PRIO      = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  core_req_i,
  output obi_resp_t core_resp_o,
  input  obi_req_t  xif_req_i,
  output obi_resp_t xif_resp_o,
  output obi_req_t  bus_req_o,
  input  obi_resp_t bus_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int unsigned   CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned   PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

  // Registered state
  logic          lock_valid_q, lock_valid_d;
  logic          lock_id_q,    lock_id_d;
  logic          rr_last_q,    rr_last_d;
  logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CW-1:0] count_q,      count_d;
  logic          err_q,        err_d;
  logic          fifo_q [MAX_OUTSTANDING];
  logic          fifo_d [MAX_OUTSTANDING];

  // Combinational helpers
  logic full;
  logic winner;
  logic sel;
  logic sel_req;
  logic handshake;
  logic head_id;
  logic pop;
  logic spurious;

  // Circular pointer advance; wraps at MAX_OUTSTANDING so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == COUNT_MAX);
  assign head_id  = fifo_q[rd_ptr_q];
  assign pop      = bus_resp_i.rvalid & (count_q != '0);
  assign spurious = bus_resp_i.rvalid & (count_q == '0);

  // Unlocked arbitration: a lone requester wins; a tie goes by priority mode.
  always_comb begin
    winner = 1'b0;
    case ({xif_req_i.req, core_req_i.req})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = FIXED_PRIO ? 1'b0 : ~rr_last_q;
      default: winner = 1'b0;
    endcase
  end

  // A stalled request freezes the selection until it is granted.
  always_comb begin
    sel     = lock_valid_q ? lock_id_q : winner;
    sel_req = sel ? xif_req_i.req : core_req_i.req;
  end

  // Downstream request mux; nothing is offered while the ID FIFO is full.
  always_comb begin
    bus_req_o     = sel ? xif_req_i : core_req_i;
    bus_req_o.req = sel_req & ~full;
  end

  assign handshake = bus_req_o.req & bus_resp_i.gnt;

  // Route gnt to the selected requester and rvalid/rdata to the FIFO head.
  always_comb begin
    core_resp_o     = '0;
    xif_resp_o      = '0;
    core_resp_o.gnt = handshake & ~sel;
    xif_resp_o.gnt  = handshake & sel;
    if (pop) begin
      if (head_id) begin
        xif_resp_o.rvalid = 1'b1;
        xif_resp_o.rdata  = bus_resp_i.rdata;
      end else begin
        core_resp_o.rvalid = 1'b1;
        core_resp_o.rdata  = bus_resp_i.rdata;
      end
    end
  end

  // Lock tracking: set on a stalled request, released by gnt or by a dropped req.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    if (lock_valid_q && !sel_req) begin
      lock_valid_d = 1'b0;
    end
    if (handshake) begin
      lock_valid_d = 1'b0;
    end else if (bus_req_o.req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
  end

  // Round-robin history: remember the last granted requester.
  always_comb begin
    rr_last_d = handshake ? sel : rr_last_q;
  end

  // ID FIFO: push the issuer on each handshake, pop on each valid response.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (handshake) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Outstanding count: a push and a pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({handshake, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Sticky error for a response that has no outstanding transaction.
  always_comb begin
    err_d = err_q | spurious;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      rr_last_q    <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      rr_last_q    <= rr_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // FIFO payload needs no reset: count_q gates every read of it.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

endmodule
